// File: rtl/mps_pkg.sv
// Shared types for the MPS pixel-group readout: FSM states, default geometry, EOF flag position.
// Pure declarations; no timing or flow control of its own.
package mps_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SNAP,
        S_SCAN,
        S_SEND,
        S_CLR,
        S_EOF
    } state_t;

    localparam int NPIX_DEF = 8;
    localparam int AW_DEF   = 3;

    // The EOF flag sits just above the (AW+1)-bit address/count field.
    function automatic int eof_bit(input int aw);
        return aw + 1;
    endfunction

endpackage

// File: rtl/mps_hit_readout_ctrl_if.sv
// Readout word link toward the column/serializer: valid/ready, word = {eof, addr-or-count}.
// A word is held by the master until a cycle with valid and ready both high.
interface mps_hit_readout_ctrl_if #(
    parameter int AW = 3
);
    logic          out_valid;
    logic          out_ready;
    logic [AW+1:0] out_data;

    modport master (
        output out_valid,
        output out_data,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        output out_ready
    );
endinterface

// File: rtl/mps_hit_pri_enc.sv
// Highest-index-first priority encoder over the snapped hit mask, plus any-hit flag.
// Purely combinational (zero latency); no flow control.
module mps_hit_pri_enc #(
    parameter int NPIX = 8,
    parameter int AW   = 3
) (
    input  logic [NPIX-1:0] i_mask,
    output logic [AW-1:0]   o_idx,
    output logic            o_any
);

    // Ascending scan: the last set bit seen is the highest index.
    always_comb begin
        o_idx = '0;
        for (int i = 0; i < NPIX; i++) begin
            if (i_mask[i]) begin
                o_idx = AW'(i);
            end
        end
    end

    assign o_any = |i_mask;

endmodule

// File: rtl/mps_hit_readout_ctrl.sv
// Pixel-group readout sequencer: snapshot hits on start, stream one address per hit, clear it, close with EOF count.
// First word 3 cycles after start, 2+RST_CYC cycles per hit; words are held stable while out_ready is low.
module mps_hit_readout_ctrl
    import mps_pkg::*;
#(
    parameter int NPIX    = NPIX_DEF,
    parameter int AW      = AW_DEF,
    parameter int RST_CYC = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NPIX-1:0]               pix_state,
    input  logic                          start,
    output logic [NPIX-1:0]               pix_reset,
    mps_hit_readout_ctrl_if.master        out_if,
    output logic                          busy,
    output logic                          done
);

    localparam int CW      = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
    localparam int EOF_BIT = eof_bit(AW);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [NPIX-1:0]  r_hit_mask;
    logic [AW:0]      r_hit_cnt;
    logic [AW-1:0]    r_cur_addr;
    logic [CW-1:0]    r_rst_cnt;
    logic             r_eof_arm;

    logic [AW-1:0]    w_enc_idx;
    logic             w_enc_any;
    logic             w_out_valid;
    logic [AW+1:0]    w_out_data;
    logic             w_xfer;
    logic             w_rst_last;

    mps_hit_pri_enc #(
        .NPIX (NPIX),
        .AW   (AW)
    ) u_pri_enc (
        .i_mask (r_hit_mask),
        .o_idx  (w_enc_idx),
        .o_any  (w_enc_any)
    );

    assign w_xfer     = w_out_valid & out_if.out_ready;
    assign w_rst_last = (r_rst_cnt == CW'(RST_CYC - 1));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (start) w_state_nxt = S_SNAP;
            S_SNAP: w_state_nxt = S_SCAN;
            S_SCAN: w_state_nxt = w_enc_any ? S_SEND : S_EOF;
            S_SEND: if (w_xfer) w_state_nxt = S_CLR;
            S_CLR:  if (w_rst_last) w_state_nxt = S_SCAN;
            S_EOF:  if (w_xfer) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_hit_mask <= '0;
            r_hit_cnt  <= '0;
            r_cur_addr <= '0;
            r_rst_cnt  <= '0;
            r_eof_arm  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_SNAP: begin
                    r_hit_mask <= pix_state;
                    r_hit_cnt  <= '0;
                end
                S_SCAN: begin
                    if (w_enc_any) r_cur_addr <= w_enc_idx;
                end
                S_SEND: begin
                    if (w_xfer) begin
                        r_hit_cnt              <= r_hit_cnt + (AW+1)'(1);
                        r_hit_mask[r_cur_addr] <= 1'b0;
                    end
                end
                S_CLR: begin
                    r_rst_cnt <= w_rst_last ? '0 : r_rst_cnt + CW'(1);
                end
                // The first EOF cycle arms the word; it is presented from the second cycle on.
                S_EOF: begin
                    r_eof_arm <= ~w_xfer;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_out_valid = 1'b0;
        w_out_data  = '0;
        pix_reset   = '0;
        case (r_state)
            S_SEND: begin
                w_out_valid         = 1'b1;
                w_out_data[AW:0]    = {1'b0, r_cur_addr};
            end
            S_EOF: begin
                if (r_eof_arm) begin
                    w_out_valid         = 1'b1;
                    w_out_data[EOF_BIT] = 1'b1;
                    w_out_data[AW:0]    = r_hit_cnt;
                end
            end
            S_CLR: pix_reset[r_cur_addr] = 1'b1;
            default: ;
        endcase
    end

    assign out_if.out_valid = w_out_valid;
    assign out_if.out_data  = w_out_data;
    assign busy             = (r_state != S_IDLE);
    assign done             = (r_state == S_EOF) & w_xfer;

endmodule
